// File: rtl/prio_encoder_rr_reg.sv
// Registered priority encoder with fixed and round-robin modes behind a valid/ready handshake.
// PrioTreeEnc is the combinational 4:2 group tree; prio_encoder_rr_reg adds the pointer and the output register.

module PrioTreeEnc #(
  parameter int WIDTH  = 16,
  parameter int CODE_W = 4
) (
  input  logic [WIDTH-1:0]  i_req,
  output logic              o_any,
  output logic [CODE_W-1:0] o_code
);

  // Levels of 4:2 groups; widths that are not a power of four are padded with idle lines.
  localparam int LEVELS = (CODE_W + 1) / 2;
  localparam int CODE_P = 2 * LEVELS;
  localparam int PAD_W  = 1 << CODE_P;
  localparam int NODES0 = PAD_W / 4;

  function automatic logic [1:0] pri4(input logic [3:0] v);
    if (v[3])      return 2'd3;
    else if (v[2]) return 2'd2;
    else if (v[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  logic [PAD_W-1:0]  w_padReq;
  logic [NODES0-1:0] w_lvlVld [LEVELS];
  logic [CODE_P-1:0] w_lvlIdx [LEVELS][NODES0];
  logic [3:0]        w_child;
  logic [1:0]        w_sel;

  assign w_padReq = PAD_W'(i_req);

  // Each node keeps the index of its highest valid child, prefixed onto that child's own index.
  always_comb begin
    w_lvlVld = '{default: '0};
    w_lvlIdx = '{default: '{default: '0}};
    w_child  = '0;
    w_sel    = '0;
    for (int n = 0; n < NODES0; n++) begin
      w_child         = w_padReq[4*n +: 4];
      w_lvlVld[0][n]  = |w_child;
      w_lvlIdx[0][n]  = CODE_P'(pri4(w_child));
    end
    for (int lv = 1; lv < LEVELS; lv++) begin
      for (int n = 0; n < (NODES0 >> (2*lv)); n++) begin
        w_child         = w_lvlVld[lv-1][4*n +: 4];
        w_sel           = pri4(w_child);
        w_lvlVld[lv][n] = |w_child;
        w_lvlIdx[lv][n] = (CODE_P'(w_sel) << (2*lv)) | w_lvlIdx[lv-1][4*n + int'(w_sel)];
      end
    end
  end

  assign o_any  = w_lvlVld[LEVELS-1][0];
  assign o_code = w_lvlIdx[LEVELS-1][0][CODE_W-1:0];

endmodule

module prio_encoder_rr_reg #(
  parameter  int WIDTH  = 16,
  localparam int CODE_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rr_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic [WIDTH-1:0]  out_grant,
  output logic              out_active
);

  logic [CODE_W-1:0] r_ptr;
  logic              r_outValid;
  logic [CODE_W-1:0] r_outCode;
  logic [WIDTH-1:0]  r_outGrant;
  logic              r_outActive;

  logic [WIDTH-1:0]  w_mask;
  logic [WIDTH-1:0]  w_maskedReq;
  logic              w_fixAny;
  logic [CODE_W-1:0] w_fixCode;
  logic              w_mskAny;
  logic [CODE_W-1:0] w_mskCode;
  logic [CODE_W-1:0] w_code;
  logic [WIDTH-1:0]  w_grant;
  logic              w_accept;

  // Round-robin looks below the last winner first; an empty mask wraps to plain priority.
  assign w_mask      = (WIDTH'(1) << r_ptr) - WIDTH'(1);
  assign w_maskedReq = in_req & w_mask;

  PrioTreeEnc #(.WIDTH(WIDTH), .CODE_W(CODE_W)) u_fixTree (
    .i_req  (in_req),
    .o_any  (w_fixAny),
    .o_code (w_fixCode)
  );

  PrioTreeEnc #(.WIDTH(WIDTH), .CODE_W(CODE_W)) u_mskTree (
    .i_req  (w_maskedReq),
    .o_any  (w_mskAny),
    .o_code (w_mskCode)
  );

  assign w_code   = !w_fixAny ? '0 : ((rr_mode && w_mskAny) ? w_mskCode : w_fixCode);
  assign w_grant  = w_fixAny ? (WIDTH'(1) << w_code) : '0;
  assign in_ready = !r_outValid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Single output stage: load on accept, otherwise hold until the consumer takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr       <= '0;
      r_outValid  <= 1'b0;
      r_outCode   <= '0;
      r_outGrant  <= '0;
      r_outActive <= 1'b0;
    end else if (w_accept) begin
      r_outValid  <= 1'b1;
      r_outCode   <= w_code;
      r_outGrant  <= w_grant;
      r_outActive <= w_fixAny;
      if (rr_mode && w_fixAny) begin
        r_ptr <= w_code;
      end
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign out_valid  = r_outValid;
  assign out_code   = r_outCode;
  assign out_grant  = r_outGrant;
  assign out_active = r_outActive;

endmodule

// File: tb/tb_prio_encoder_rr_reg.sv
// Randomised scoreboard bench for prio_encoder_rr_reg at WIDTH 16, 64 and 4.
// A loop-based reference model predicts each accepted vector; monitors compare on every valid output.

module tb_prio_encoder_rr_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        rr16, inValid16, inReady16, outValid16, outReady16, outActive16;
  logic [15:0] inReq16, outGrant16;
  logic [3:0]  outCode16;

  logic        rr64, inValid64, inReady64, outValid64, outReady64, outActive64;
  logic [63:0] inReq64, outGrant64;
  logic [5:0]  outCode64;

  logic        rr4, inValid4, inReady4, outValid4, outReady4, outActive4;
  logic [3:0]  inReq4, outGrant4;
  logic [1:0]  outCode4;

  prio_encoder_rr_reg #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .rr_mode(rr16), .in_valid(inValid16), .in_ready(inReady16),
    .in_req(inReq16), .out_valid(outValid16), .out_ready(outReady16), .out_code(outCode16),
    .out_grant(outGrant16), .out_active(outActive16)
  );

  prio_encoder_rr_reg #(.WIDTH(64)) dut64 (
    .clk(clk), .reset(reset), .rr_mode(rr64), .in_valid(inValid64), .in_ready(inReady64),
    .in_req(inReq64), .out_valid(outValid64), .out_ready(outReady64), .out_code(outCode64),
    .out_grant(outGrant64), .out_active(outActive64)
  );

  prio_encoder_rr_reg #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .rr_mode(rr4), .in_valid(inValid4), .in_ready(inReady4),
    .in_req(inReq4), .out_valid(outValid4), .out_ready(outReady4), .out_code(outCode4),
    .out_grant(outGrant4), .out_active(outActive4)
  );

  typedef struct {
    int          code;
    logic [63:0] grant;
    bit          active;
  } expT;

  expT q16[$];
  expT q64[$];
  expT q4[$];
  expT mon16, mon64, mon4;

  int mdlPtr16, mdlPtr64, mdlPtr4;
  bit mdlValid16;
  int checks   = 0;
  int failures = 0;

  // Reference: scan downward from just below the pointer, then wrap to a full downward scan.
  function automatic expT refResult(input logic [63:0] req, input int ptr, input bit rr,
                                    input int width);
    expT r;
    r.code   = 0;
    r.active = 1'b0;
    r.grant  = '0;
    for (int i = 0; i < width; i++) if (req[i]) r.active = 1'b1;
    if (r.active) begin
      bit found = 1'b0;
      if (rr) begin
        for (int i = ptr - 1; i >= 0; i--) begin
          if (!found && req[i]) begin r.code = i; found = 1'b1; end
        end
      end
      for (int i = width - 1; i >= 0; i--) begin
        if (!found && req[i]) begin r.code = i; found = 1'b1; end
      end
      r.grant = 64'(1) << r.code;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit vld, input logic [15:0] req, input bit rr, input bit ordy);
    expT e;
    bit  rdy;
    inValid16  = vld;
    inReq16    = req;
    rr16       = rr;
    outReady16 = ordy;
    @(negedge clk);
    rdy = !mdlValid16 || ordy;
    checkOutput("in_ready16", 64'(inReady16), 64'(rdy));
    if (vld && rdy) begin
      e = refResult(64'(req), mdlPtr16, rr, 16);
      q16.push_back(e);
      if (rr && e.active) mdlPtr16 = e.code;
      mdlValid16 = 1'b1;
    end else if (ordy) begin
      mdlValid16 = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyWide(input bit vld, input logic [63:0] req, input bit rr);
    expT e;
    inValid64 = vld;
    inReq64   = req;
    rr64      = rr;
    @(negedge clk);
    checkOutput("in_ready64", 64'(inReady64), 64'(1));
    if (vld) begin
      e = refResult(req, mdlPtr64, rr, 64);
      q64.push_back(e);
      if (rr && e.active) mdlPtr64 = e.code;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyNarrow(input bit vld, input logic [3:0] req, input bit rr);
    expT e;
    inValid4 = vld;
    inReq4   = req;
    rr4      = rr;
    @(negedge clk);
    checkOutput("in_ready4", 64'(inReady4), 64'(1));
    if (vld) begin
      e = refResult(64'(req), mdlPtr4, rr, 4);
      q4.push_back(e);
      if (rr && e.active) mdlPtr4 = e.code;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    inValid16 = 1'b0;
    inValid64 = 1'b0;
    inValid4  = 1'b0;
    reset     = 1'b1;
    #2;
    checkOutput("rst_valid16",  64'(outValid16),  64'(0));
    checkOutput("rst_code16",   64'(outCode16),   64'(0));
    checkOutput("rst_grant16",  64'(outGrant16),  64'(0));
    checkOutput("rst_active16", 64'(outActive16), 64'(0));
    checkOutput("rst_ready16",  64'(inReady16),   64'(1));
    checkOutput("rst_valid64",  64'(outValid64),  64'(0));
    checkOutput("rst_valid4",   64'(outValid4),   64'(0));
    q16.delete();
    q64.delete();
    q4.delete();
    mdlPtr16   = 0;
    mdlPtr64   = 0;
    mdlPtr4    = 0;
    mdlValid16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && outValid16) begin
      if (q16.size() == 0) begin
        checkOutput("out16_spurious_valid", 64'(outValid16), 64'(0));
      end else begin
        mon16 = q16[0];
        checkOutput("out16_code",   64'(outCode16),   64'(mon16.code));
        checkOutput("out16_grant",  64'(outGrant16),  mon16.grant);
        checkOutput("out16_active", 64'(outActive16), 64'(mon16.active));
        if (outReady16) void'(q16.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && outValid64) begin
      if (q64.size() == 0) begin
        checkOutput("out64_spurious_valid", 64'(outValid64), 64'(0));
      end else begin
        mon64 = q64.pop_front();
        checkOutput("out64_code",   64'(outCode64),   64'(mon64.code));
        checkOutput("out64_grant",  outGrant64,       mon64.grant);
        checkOutput("out64_active", 64'(outActive64), 64'(mon64.active));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && outValid4) begin
      if (q4.size() == 0) begin
        checkOutput("out4_spurious_valid", 64'(outValid4), 64'(0));
      end else begin
        mon4 = q4.pop_front();
        checkOutput("out4_code",   64'(outCode4),   64'(mon4.code));
        checkOutput("out4_grant",  64'(outGrant4),  mon4.grant);
        checkOutput("out4_active", 64'(outActive4), 64'(mon4.active));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] req16;
    rr16 = 1'b0; inReq16 = '0; outReady16 = 1'b1;
    rr64 = 1'b0; inReq64 = '0; outReady64 = 1'b1;
    rr4  = 1'b0; inReq4  = '0; outReady4  = 1'b1;
    doReset();

    applyStimulus(1'b1, 16'h0000, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b1, 16'h8421, 1'b0, 1'b1);
    repeat (5) applyStimulus(1'b1, 16'h8421, 1'b1, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);

    // Stall after the first round-robin result, then resume and reset while a result is held.
    doReset();
    applyStimulus(1'b1, 16'h8421, 1'b1, 1'b1);
    repeat (4) applyStimulus(1'b1, 16'h8421, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h8421, 1'b1, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    doReset();
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
    applyStimulus(1'b1, 16'h8421, 1'b1, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);

    repeat (400) begin
      case ($urandom_range(0, 3))
        0:       req16 = '0;
        1:       req16 = 16'(1) << $urandom_range(0, 15);
        2:       req16 = 16'($urandom);
        default: req16 = 16'($urandom) & 16'($urandom);
      endcase
      applyStimulus($urandom_range(0, 3) != 0, req16, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) != 0);
    end
    repeat (2) applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    checkOutput("q16_drain", 64'(q16.size()), 64'(0));

    for (int i = 0; i < 64; i++) applyWide(1'b1, 64'(1) << i, 1'b0);
    repeat (65) applyWide(1'b1, {64{1'b1}}, 1'b1);
    repeat (100) applyWide(1'($urandom_range(0, 1)), {$urandom, $urandom} & {$urandom, $urandom},
                           1'($urandom_range(0, 1)));
    repeat (2) applyWide(1'b0, 64'(0), 1'b0);
    checkOutput("q64_drain", 64'(q64.size()), 64'(0));

    for (int i = 0; i < 4; i++) applyNarrow(1'b1, 4'(1) << i, 1'b0);
    repeat (5) applyNarrow(1'b1, 4'hF, 1'b1);
    repeat (60) applyNarrow(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));
    repeat (2) applyNarrow(1'b0, 4'h0, 1'b0);
    checkOutput("q4_drain", 64'(q4.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
